// File: rtl/uart_pkg.sv
// Shared types and helpers for the configurable UART transmitter.
// Holds the frame state encoding, parity modes and divisor clamping.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } tx_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      ODD  = 2'd1,
      EVEN = 2'd2,
      MARK = 2'd3
   } parity_t;

   localparam logic [1:0] DLEN_5 = 2'd0;
   localparam logic [1:0] DLEN_6 = 2'd1;
   localparam logic [1:0] DLEN_7 = 2'd2;
   localparam logic [1:0] DLEN_8 = 2'd3;

   // A zero divisor selects the default; one is raised to two so every bit spans at least two clocks.
   function automatic logic [31:0] eff_div(input logic [31:0] div, input logic [31:0] dflt);
      logic [31:0] r;
      if (div == 32'd0) begin
         r = dflt;
      end else if (div == 32'd1) begin
         r = 32'd2;
      end else begin
         r = div;
      end
      return r;
   endfunction

   function automatic logic par_bit(input parity_t mode, input logic xor_acc);
      logic r;
      case (mode)
         ODD:     r = ~xor_acc;
         EVEN:    r = xor_acc;
         MARK:    r = 1'b1;
         default: r = 1'b1;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Loadable bit-period down-counter; ticks on the last clock of a bit.
module uart_baud_tick #(
   parameter int CNT_W = 24
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic [CNT_W-1:0] i_load_val,
   input  logic             i_en,
   output logic             o_tick
);

   logic [CNT_W-1:0] cnt_r;

   assign o_tick = i_en && (cnt_r == {CNT_W{1'b0}});

   // Count down toward zero; a load always takes priority.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (i_load) begin
         cnt_r <= i_load_val;
      end else if (i_en && (cnt_r != {CNT_W{1'b0}})) begin
         cnt_r <= cnt_r - CNT_W'(1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

endmodule

// File: rtl/uart_tx_cfg.sv
// Runtime-configurable UART transmitter: 5-8 data bits, none/odd/even/mark
// parity, 1 or 2 stop bits, per-character baud divisor.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int CNT_W       = 24,
   parameter int DEFAULT_DIV = 868
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr,
   input  logic [7:0]       i_data,
   input  logic [1:0]       i_data_bits,
   input  logic [1:0]       i_parity,
   input  logic             i_stop2,
   input  logic [CNT_W-1:0] i_divisor,
   output logic             o_uart_tx,
   output logic             o_busy,
   output logic             o_done
);

   tx_state_t        state_r, state_s;
   logic [7:0]       shift_r, shift_s;
   logic [2:0]       idx_r, idx_s, last_idx_s;
   logic [1:0]       dlen_r, dlen_s;
   parity_t          par_r, par_s;
   logic             stop2_r, stop2_s, stop_idx_r, stop_idx_s;
   logic             acc_r, acc_s, acc_next_s;
   logic [CNT_W-1:0] div_r, div_s, eff_s, load_val_s;
   logic             tx_r, tx_s, busy_r, busy_s, done_r, done_s;
   logic             load_s, en_s, tick_s, trigger_s;

   assign trigger_s  = i_wr && !busy_r;
   assign eff_s      = CNT_W'(eff_div(32'(i_divisor), 32'(DEFAULT_DIV)));
   assign en_s       = (state_r != IDLE);
   assign acc_next_s = acc_r ^ shift_r[0];
   assign o_uart_tx  = tx_r;
   assign o_busy     = busy_r;
   assign o_done     = done_r;

   uart_baud_tick #(.CNT_W(CNT_W)) u_tick (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_load     (load_s),
      .i_load_val (load_val_s),
      .i_en       (en_s),
      .o_tick     (tick_s)
   );

   // Index of the final data bit for the latched data length.
   always_comb begin
      case (dlen_r)
         DLEN_5:  last_idx_s = 3'd4;
         DLEN_6:  last_idx_s = 3'd5;
         DLEN_7:  last_idx_s = 3'd6;
         DLEN_8:  last_idx_s = 3'd7;
         default: last_idx_s = 3'd7;
      endcase
   end

   // Frame sequencing, shifting and parity accumulation.
   always_comb begin
      state_s    = state_r;
      shift_s    = shift_r;
      idx_s      = idx_r;
      dlen_s     = dlen_r;
      par_s      = par_r;
      stop2_s    = stop2_r;
      stop_idx_s = stop_idx_r;
      acc_s      = acc_r;
      div_s      = div_r;
      tx_s       = tx_r;
      busy_s     = busy_r;
      done_s     = 1'b0;
      load_s     = 1'b0;
      load_val_s = div_r - CNT_W'(1);
      case (state_r)
         IDLE: begin
            tx_s   = 1'b1;
            busy_s = 1'b0;
            if (trigger_s) begin
               state_s    = START;
               tx_s       = 1'b0;
               busy_s     = 1'b1;
               shift_s    = i_data;
               dlen_s     = i_data_bits;
               par_s      = parity_t'(i_parity);
               stop2_s    = i_stop2;
               div_s      = eff_s;
               idx_s      = 3'd0;
               acc_s      = 1'b0;
               stop_idx_s = 1'b0;
               load_s     = 1'b1;
               load_val_s = eff_s - CNT_W'(1);
            end else begin
               state_s = IDLE;
            end
         end
         START: begin
            if (tick_s) begin
               state_s = DATA;
               tx_s    = shift_r[0];
               load_s  = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         DATA: begin
            if (tick_s) begin
               acc_s   = acc_next_s;
               shift_s = shift_r >> 1;
               load_s  = 1'b1;
               if (idx_r == last_idx_s) begin
                  stop_idx_s = 1'b0;
                  if (par_r != NONE) begin
                     state_s = PARITY;
                     tx_s    = par_bit(par_r, acc_next_s);
                  end else begin
                     state_s = STOP;
                     tx_s    = 1'b1;
                  end
               end else begin
                  idx_s = idx_r + 3'd1;
                  tx_s  = shift_r[1];
               end
            end else begin
               load_s = 1'b0;
            end
         end
         PARITY: begin
            if (tick_s) begin
               state_s    = STOP;
               tx_s       = 1'b1;
               stop_idx_s = 1'b0;
               load_s     = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         STOP: begin
            if (tick_s && stop2_r && !stop_idx_r) begin
               stop_idx_s = 1'b1;
               load_s     = 1'b1;
            end else if (tick_s) begin
               state_s = IDLE;
               busy_s  = 1'b0;
               done_s  = 1'b1;
               tx_s    = 1'b1;
            end else begin
               load_s = 1'b0;
            end
         end
         default: begin
            state_s = IDLE;
            tx_s    = 1'b1;
            busy_s  = 1'b0;
         end
      endcase
   end

   // State, datapath and registered outputs; reset aborts any frame with the line high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r    <= IDLE;
         shift_r    <= 8'd0;
         idx_r      <= 3'd0;
         dlen_r     <= 2'd0;
         par_r      <= NONE;
         stop2_r    <= 1'b0;
         stop_idx_r <= 1'b0;
         acc_r      <= 1'b0;
         div_r      <= {CNT_W{1'b0}};
         tx_r       <= 1'b1;
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         state_r    <= state_s;
         shift_r    <= shift_s;
         idx_r      <= idx_s;
         dlen_r     <= dlen_s;
         par_r      <= par_s;
         stop2_r    <= stop2_s;
         stop_idx_r <= stop_idx_s;
         acc_r      <= acc_s;
         div_r      <= div_s;
         tx_r       <= tx_s;
         busy_r     <= busy_s;
         done_r     <= done_s;
      end
   end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Self-checking bench for uart_tx_cfg: directed frames plus random frames
// compared cycle by cycle against an expected line waveform.
module tb_uart_tx_cfg;

   localparam int CNT_W   = 24;
   localparam int DEF_DIV = 5;

   logic             i_clk = 1'b0;
   logic             i_rst_n = 1'b0;
   logic             i_wr = 1'b0;
   logic [7:0]       i_data = 8'd0;
   logic [1:0]       i_data_bits = 2'd0;
   logic [1:0]       i_parity = 2'd0;
   logic             i_stop2 = 1'b0;
   logic [CNT_W-1:0] i_divisor = '0;
   logic             o_uart_tx, o_busy, o_done;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 i_clk = ~i_clk;

   uart_tx_cfg #(.CNT_W(CNT_W), .DEFAULT_DIV(DEF_DIV)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_wr        (i_wr),
      .i_data      (i_data),
      .i_data_bits (i_data_bits),
      .i_parity    (i_parity),
      .i_stop2     (i_stop2),
      .i_divisor   (i_divisor),
      .o_uart_tx   (o_uart_tx),
      .o_busy      (o_busy),
      .o_done      (o_done)
   );

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
      end
   endtask

   function automatic int eff(input int d);
      if (d == 0) return DEF_DIV;
      if (d == 1) return 2;
      return d;
   endfunction

   // Idle line: {tx, busy, done} = 3'b100 each cycle.
   task automatic idle_check(input int n, input string tag);
      for (int i = 0; i < n; i++) begin
         @(negedge i_clk);
         check_eq(tag, {29'd0, o_uart_tx, o_busy, o_done}, 32'd4);
      end
   endtask

   // Called with the clock low; triggers on the next rising edge and checks the whole frame.
   task automatic run_frame(input logic [7:0] data, input int dbits, input int par, input int stops,
                            input int div_in, input bit keep, input bit disturb, input string tag);
      bit exp_q[$];
      int d, ones, total, poke;
      d    = eff(div_in);
      ones = 0;
      exp_q.push_back(1'b0);
      for (int i = 0; i < dbits; i++) begin
         exp_q.push_back(data[i]);
         ones += int'(data[i]);
      end
      case (par)
         1:       exp_q.push_back((ones % 2) == 0);
         2:       exp_q.push_back((ones % 2) == 1);
         3:       exp_q.push_back(1'b1);
         default: ;
      endcase
      for (int s = 0; s < stops; s++) exp_q.push_back(1'b1);
      total = d * exp_q.size();

      i_wr        = 1'b1;
      i_data      = data;
      i_data_bits = 2'(dbits - 5);
      i_parity    = 2'(par);
      i_stop2     = (stops == 2);
      i_divisor   = CNT_W'(div_in);
      @(posedge i_clk);
      #1;
      if (!keep) i_wr = 1'b0;
      poke = -10;
      if (disturb) begin
         i_data      = 8'($urandom);
         i_parity    = 2'($urandom);
         i_data_bits = 2'($urandom);
         i_stop2     = 1'($urandom);
         i_divisor   = CNT_W'($urandom_range(1, 9));
         poke        = $urandom_range(0, total - 3);
      end
      for (int k = 0; k < total; k++) begin
         @(negedge i_clk);
         check_eq(tag, {29'd0, o_uart_tx, o_busy, o_done}, {29'd0, exp_q[k / d], 1'b1, 1'b0});
         if (k == poke) begin
            i_wr   = 1'b1;
            i_data = 8'hAA;
         end else if (k == poke + 1) begin
            i_wr = 1'b0;
         end
      end
      @(negedge i_clk);
      check_eq({tag, "_end"}, {29'd0, o_uart_tx, o_busy, o_done}, 32'd5);
   endtask

   initial begin
      #12;
      check_eq("reset_state", {29'd0, o_uart_tx, o_busy, o_done}, 32'd4);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      idle_check(2, "idle_after_reset");

      run_frame(8'h55, 8, 0, 1, 4, 1'b0, 1'b0, "8N1_55");
      idle_check(2, "idle_8N1");
      run_frame(8'hC1, 7, 2, 1, 3, 1'b0, 1'b0, "7E1_C1");
      run_frame(8'h07, 5, 1, 2, 2, 1'b0, 1'b0, "5O2_07");
      run_frame(8'hA5, 8, 0, 1, 1, 1'b0, 1'b0, "div1");
      run_frame(8'h3C, 6, 3, 1, 0, 1'b0, 1'b0, "div0");
      idle_check(1, "idle_div");

      run_frame(8'h81, 8, 0, 1, 3, 1'b1, 1'b0, "b2b_a");
      run_frame(8'h7E, 8, 2, 2, 3, 1'b1, 1'b0, "b2b_b");
      run_frame(8'h12, 5, 0, 1, 2, 1'b0, 1'b0, "b2b_c");
      idle_check(2, "idle_b2b");

      run_frame(8'h0F, 8, 0, 1, 4, 1'b0, 1'b1, "busy_wr_0F");
      idle_check(3, "no_queued_write");

      // Reset during data bit 3 of an all-zero character.
      i_wr        = 1'b1;
      i_data      = 8'h00;
      i_data_bits = 2'd3;
      i_parity    = 2'd0;
      i_stop2     = 1'b0;
      i_divisor   = CNT_W'(4);
      @(posedge i_clk);
      #1;
      i_wr = 1'b0;
      repeat (18) @(negedge i_clk);
      check_eq("pre_reset_bit3", {29'd0, o_uart_tx, o_busy, o_done}, 32'd2);
      #2;
      i_rst_n = 1'b0;
      #1;
      check_eq("async_reset", {29'd0, o_uart_tx, o_busy, o_done}, 32'd4);
      @(negedge i_clk);
      check_eq("held_reset", {29'd0, o_uart_tx, o_busy, o_done}, 32'd4);
      i_rst_n = 1'b1;
      idle_check(1, "idle_post_reset");
      run_frame(8'h3C, 8, 0, 1, 4, 1'b0, 1'b0, "post_reset_3C");

      for (int i = 0; i < 16; i++) begin
         bit k;
         k = 1'($urandom_range(0, 1));
         run_frame(8'($urandom), $urandom_range(5, 8), $urandom_range(0, 3), $urandom_range(1, 2),
                   $urandom_range(0, 6), k, !k && 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
      end
      i_wr = 1'b0;
      idle_check(3, "idle_final");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
